// File: rtl/load_byte_sequencer.sv
// load_byte_sequencer
//   Turns one RISC-V style load request (LB/LH/LW/LBU/LHU) into a series of
//   single-byte memory reads, assembles the bytes little-endian and returns
//   the sign- or zero-extended 32-bit result as a one-cycle response.
//
// Ports
//   clock, reset_n              : clock (rising edge), asynchronous active-low reset
//   req_valid / req_ready       : request handshake; ready only while idle
//   req_addr, req_funct3        : byte address and load type of the request
//   mem_rd_en, mem_addr         : one-cycle byte-read strobe and its address
//   mem_rd_data, mem_rd_valid   : returned byte and its qualifier
//   rsp_valid                   : one-cycle result pulse
//   rsp_data, rsp_err           : extended result / illegal-funct3 flag, held
//                                 until the next response
//   busy                        : stall indication, high whenever not idle
module load_byte_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [2:0]        req_funct3,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rd_data,
   input  logic              mem_rd_valid,
   output logic              rsp_valid,
   output logic [31:0]       rsp_data,
   output logic              rsp_err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   base_q;
   logic [2:0]          funct3_q;
   logic [2:0]          nbytes_q;
   logic [2:0]          index_q;
   logic [31:0]         buf_q;
   logic                mem_rd_en_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic                rsp_valid_q;
   logic [31:0]         rsp_data_q;
   logic                rsp_err_q;

   logic [31:0]         buf_d;
   logic [2:0]          index_d;
   logic [2:0]          req_nbytes;

   // Number of bytes a load type reads; 0 marks an illegal funct3.
   function automatic logic [2:0] decode_nbytes(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: decode_nbytes = 3'd1;
         3'b001, 3'b101: decode_nbytes = 3'd2;
         3'b010:         decode_nbytes = 3'd4;
         default:        decode_nbytes = 3'd0;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
      case (f3)
         3'b000:  extend = {{24{raw[7]}}, raw[7:0]};
         3'b100:  extend = {24'd0, raw[7:0]};
         3'b001:  extend = {{16{raw[15]}}, raw[15:0]};
         3'b101:  extend = {16'd0, raw[15:0]};
         default: extend = raw;
      endcase
   endfunction

   assign req_nbytes = decode_nbytes(req_funct3);
   assign index_d    = index_q + 3'd1;

   // Buffer with the arriving byte merged into its lane; the final byte lands
   // on the same edge that enters DONE, so the response is built from this.
   always_comb begin
      buf_d = buf_q;
      buf_d[8*index_q[1:0] +: 8] = mem_rd_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         base_q      <= '0;
         funct3_q    <= 3'd0;
         nbytes_q    <= 3'd0;
         index_q     <= 3'd0;
         buf_q       <= 32'd0;
         mem_rd_en_q <= 1'b0;
         mem_addr_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 32'd0;
         rsp_err_q   <= 1'b0;
      end else begin
         mem_rd_en_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  base_q   <= req_addr;
                  funct3_q <= req_funct3;
                  nbytes_q <= req_nbytes;
                  index_q  <= 3'd0;
                  buf_q    <= 32'd0;
                  if (req_nbytes == 3'd0) begin
                     // Illegal load type: respond at once, no memory traffic.
                     state_q     <= DONE;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_data_q  <= 32'd0;
                  end else begin
                     state_q     <= ISSUE;
                     mem_rd_en_q <= 1'b1;
                     mem_addr_q  <= req_addr;
                  end
               end
            end
            ISSUE: state_q <= WAIT;
            WAIT: begin
               if (mem_rd_valid) begin
                  buf_q   <= buf_d;
                  index_q <= index_d;
                  if (index_d < nbytes_q) begin
                     state_q     <= ISSUE;
                     mem_rd_en_q <= 1'b1;
                     mem_addr_q  <= base_q + ADDR_W'(index_d);
                  end else begin
                     state_q     <= DONE;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b0;
                     rsp_data_q  <= extend(buf_d, funct3_q);
                  end
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign mem_rd_en = mem_rd_en_q;
   assign mem_addr  = mem_addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: doc/load_byte_sequencer.md
LOAD_BYTE_SEQUENCER -- requirements
Module: load_byte_sequencer

Interface
REQ-001 The block SHALL have one parameter, ADDR_W, default 32, giving the width of the request and memory addresses.
REQ-002 The block SHALL have port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1: a load request is present.
REQ-005 The block SHALL have port req_ready, output, 1: high only in IDLE.
REQ-006 The block SHALL have port req_addr, input, ADDR_W: byte address of the load.
REQ-007 The block SHALL have port req_funct3, input, 3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes illegal.
REQ-008 The block SHALL have port mem_rd_en, output, 1: a one-cycle byte-read strobe.
REQ-009 The block SHALL have port mem_addr, output, ADDR_W: byte address of the current read.
REQ-010 The block SHALL have port mem_rd_data, input, 8: returned byte.
REQ-011 The block SHALL have port mem_rd_valid, input, 1: mem_rd_data is valid this cycle.
REQ-012 The block SHALL have port rsp_valid, output, 1: a one-cycle result pulse.
REQ-013 The block SHALL have port rsp_data, output, 32: the extended load result.
REQ-014 The block SHALL have port rsp_err, output, 1: the request had an illegal funct3.
REQ-015 The block SHALL have port busy, output, 1: a CPU stall; high whenever the state is not IDLE.

Function
REQ-016 The FSM SHALL use exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-017 The handshake SHALL fire when req_valid and req_ready are both high on a rising edge.
- On that edge, req_addr is captured as base, funct3 is decoded to byte count N (1, 2 or 4), the byte index is set to 0 and the byte buffer is cleared.
- req_valid while req_ready is low SHALL be ignored.
REQ-018 ISSUE SHALL last exactly one cycle, with mem_rd_en=1 and mem_addr=base+index (mod 2^ADDR_W; wrap-around permitted); the next state is WAIT.
REQ-019 WAIT SHALL hold mem_rd_en=0 and remain until mem_rd_valid=1.
- On that edge, mem_rd_data is stored into buffer byte lane [index] (little-endian) and index increments.
- The next state is ISSUE if the incremented index < N, else DONE.
REQ-020 mem_rd_valid SHALL be ignored in IDLE, ISSUE and DONE.
REQ-021 DONE SHALL last one cycle with rsp_valid=1, then return to IDLE; there is no response backpressure.
REQ-022 Extension SHALL follow funct3:
- LB: bit 7 replicated into bits 31:8.
- LBU: bits 31:8 = 0.
- LH: bit 15 replicated into bits 31:16.
- LHU: bits 31:16 = 0.
- LW: the buffer is passed unmodified.
REQ-023 An illegal funct3 SHALL go IDLE -> DONE directly with no memory read, and DONE SHALL drive rsp_err=1, rsp_data=0.
REQ-024 rsp_data and rsp_err SHALL update on entry to DONE and hold until the next DONE.
REQ-025 Latency: with mem_rd_valid arriving the cycle after every mem_rd_en, rsp_valid SHALL be high 2N edges after the accepting edge.
- That is 2, 4 and 8 edges for byte, half and word loads.
- An illegal funct3 responds 1 edge after acceptance.
REQ-026 A new request SHALL be accepted no earlier than the edge after DONE (one idle cycle minimum between transactions).
REQ-027 Address alignment SHALL NOT be checked; misaligned LH/LW are legal and read consecutive bytes.

Reset
REQ-028 While reset_n=0, regardless of clock, the block SHALL hold:
- state IDLE, index 0, buffer 0;
- mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, req_ready=1.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no rsp_valid, and a late mem_rd_valid after release SHALL be ignored.

Verification
REQ-030 LB, addr 0x100, byte 0x80 returned with 1-cycle latency -> one mem_rd_en at 0x100; rsp_data=0xFFFFFF80, rsp_err=0, rsp_valid 2 edges after accept.
REQ-031 LHU, addr 0x201, bytes 0x34 then 0xF2 -> reads at 0x201 and 0x202; rsp_data=0x0000F234; rsp_valid 4 edges after accept.
REQ-032 LW, addr 0xFFFFFFFE, bytes 0x11/0x22/0x33/0x44, mem_rd_valid delayed 3 cycles each -> mem_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001; rsp_data=0x44332211; busy high throughout.
REQ-033 funct3=011 -> no mem_rd_en; rsp_valid 1 edge after accept with rsp_err=1, rsp_data=0.
REQ-034 reset_n pulsed low during WAIT of the second byte of an LH, then mem_rd_valid=1 after release -> no rsp_valid; all outputs at reset values; the next LB completes normally.
REQ-035 Spurious mem_rd_valid in IDLE, and req_valid held high while busy -> both ignored; exactly one transaction per handshake.
